// File: rtl/regfile_wr_arbiter.sv
// WB/MDU register-file write arbiter: WB has priority, MDU wins after STARVE_LIMIT denials; WR_ARB_STATS_EN adds arb_conflicts.
// Latency: grant is combinational, the write strobe/address/data are registered and appear one edge after the transfer.
// Backpressure: the losing requester sees ready low and must hold valid/reg/data until it is granted.
module regfile_wr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_reg_write,
  output logic [4:0]  rf_w_reg,
  output logic [31:0] rf_in_data
`ifdef WR_ARB_STATS_EN
  ,
  output logic [15:0] arb_conflicts
`endif
);

  typedef enum logic {NORMAL, STARVED} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        wb_xfer, mdu_xfer, any_xfer;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

  always_comb begin
    wb_ready  = 1'b0;
    mdu_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        STARVED: begin
          if (mdu_valid)     mdu_ready = 1'b1;
          else if (wb_valid) wb_ready  = 1'b1;
        end
        default: begin
          if (wb_valid)       wb_ready  = 1'b1;
          else if (mdu_valid) mdu_ready = 1'b1;
        end
      endcase
    end
  end

  assign wb_xfer  = wb_valid && wb_ready;
  assign mdu_xfer = mdu_valid && mdu_ready;
  assign any_xfer = wb_xfer || mdu_xfer;
  assign sel_reg  = mdu_xfer ? mdu_reg  : wb_reg;
  assign sel_data = mdu_xfer ? mdu_data : wb_data;

  // The counter cannot pass LIMIT in practice; the 4'hF guard only keeps it from wrapping.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    state_d      = state_q;
    if (mdu_xfer) begin
      starve_cnt_d = 4'd0;
    end else if (mdu_valid && (starve_cnt_q != 4'hF)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    case (state_q)
      STARVED: if (mdu_xfer) state_d = NORMAL;
      default: if (!mdu_xfer && (starve_cnt_d >= LIMIT)) state_d = STARVED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Register 0 is hardwired: its transfers complete but never raise the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_reg_write <= 1'b0;
      rf_w_reg     <= 5'd0;
      rf_in_data   <= 32'd0;
    end else begin
      rf_reg_write <= any_xfer && (sel_reg != 5'd0);
      if (any_xfer) begin
        rf_w_reg   <= sel_reg;
        rf_in_data <= sel_data;
      end
    end
  end

`ifdef WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_conflicts <= 16'd0;
    end else if (wb_valid && mdu_valid && (arb_conflicts != 16'hFFFF)) begin
      arb_conflicts <= arb_conflicts + 16'd1;
    end
  end
`endif

  ap_one_ready: assert property (@(posedge clk) !(wb_ready && mdu_ready));
  ap_no_ready_in_rst: assert property (@(posedge clk) rst |-> !(wb_ready || mdu_ready));

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive denied MDU cycles before MDU is forced to win (legal 1..15).
REQ-002 clk  input  1  clock; the arbiter updates on the rising edge, and the register file writes on the following falling edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wb_valid  input  1  pipeline writeback stage requests a register write.
REQ-005 wb_reg  input  5  writeback destination register.
REQ-006 wb_data  input  32  writeback data.
REQ-007 wb_ready  output  1  writeback request accepted this cycle (combinational).
REQ-008 mdu_valid  input  1  multiply/divide unit requests a register write.
REQ-009 mdu_reg  input  5  MDU destination register.
REQ-010 mdu_data  input  32  MDU data.
REQ-011 mdu_ready  output  1  MDU request accepted this cycle (combinational).
REQ-012 rf_reg_write  output  1  registered write enable to the register file.
REQ-013 rf_w_reg  output  5  registered write address.
REQ-014 rf_in_data  output  32  registered write data.
REQ-015 arb_conflicts  output  16  saturating conflict counter (present only when the macro in REQ-031 is defined).

Function
REQ-016 A transfer on a port SHALL occur in any cycle where both its valid and its ready are high; while valid is high, the requester holds valid, reg and data stable until the transfer.
REQ-017 At most one of wb_ready and mdu_ready SHALL be high in any cycle, and neither SHALL be high while rst is high.
REQ-018 With only one valid high, that requester SHALL be granted in the same cycle.
REQ-019 With both valids high in state NORMAL, WB SHALL be granted; in state STARVED, MDU SHALL be granted.
REQ-020 A 4-bit starve counter SHALL increment each cycle mdu_valid is high and mdu_ready is low, and SHALL clear on any MDU transfer.
REQ-021 The state machine has two states, NORMAL and STARVED. NORMAL SHALL go to STARVED on the edge where the counter's next value reaches STARVE_LIMIT. STARVED SHALL return to NORMAL on the edge following an MDU transfer.
REQ-022 Latency: a transfer in cycle N SHALL drive rf_reg_write=1, rf_w_reg and rf_in_data with the granted payload from the rising edge ending cycle N, for exactly one cycle.
REQ-023 In any cycle without a transfer, rf_reg_write SHALL be 0 on the next edge, and rf_w_reg and rf_in_data SHALL hold their previous values.
REQ-024 A transfer with destination register 0 SHALL still complete the handshake but SHALL produce rf_reg_write=0, so register 0 is never written.
REQ-025 When both requesters target the same register, the two writes SHALL be issued in grant order in separate cycles; the later grant's value persists.
REQ-026 Back-to-back transfers SHALL sustain one write per cycle with no bubble.

Reset
REQ-027 When rst is high at a rising edge, all of the following SHALL be set: rf_reg_write=0, rf_w_reg=0, rf_in_data=0, starve counter=0, state=NORMAL, and arb_conflicts=0 when present.
REQ-028 Assertion of rst mid-operation SHALL drop any ungranted request without a write, and requesters SHALL re-present it after reset.
REQ-029 In the first cycle after rst deasserts, requests SHALL be granted normally.
REQ-030 No reset behaviour SHALL depend on initial blocks.

Configuration
REQ-031 With macro WR_ARB_STATS_EN defined, arb_conflicts SHALL exist. It SHALL increment by 1 each cycle both valids are high and SHALL saturate at 16'hFFFF.
REQ-032 Without WR_ARB_STATS_EN, the arb_conflicts port and its counter SHALL be absent, and arbitration SHALL be identical.

Verification
REQ-033 Scenario 1: reset with both valids high -> both readys 0 and rf_reg_write=0. After release, single wb_valid with reg=5, data=32'hDEADBEEF -> next cycle rf_reg_write=1, rf_w_reg=5, rf_in_data=32'hDEADBEEF.
REQ-034 Scenario 2: both valids held continuously, STARVE_LIMIT=4 -> WB is granted in cycles 0-3 and MDU in cycle 4, then WB again; the pattern repeats every 5 cycles.
REQ-035 Scenario 3: wb_reg=0 and data=32'h1 transfer -> wb_ready=1 and rf_reg_write stays 0.
REQ-036 Scenario 4: WB and MDU both target reg 9 in the same cycle with data A=32'hA and B=32'hB -> writes occur in order A then B on consecutive cycles, and register 9 ends at 32'hB.
REQ-037 Scenario 5: rst pulsed while the MDU has waited 3 cycles -> counter=0 and state NORMAL; after release with both valid, WB is granted.
REQ-038 Scenario 6 (WR_ARB_STATS_EN defined): 70000 conflict cycles -> arb_conflicts=16'hFFFF; after reset -> 0.
